// File: rtl/dmem_pkg.sv
// Shared op encodings, FSM state type and op normalisation helper for the
// data-memory arbiter.
package dmem_pkg;

  localparam logic [2:0] OP_NONE = 3'b000;

  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LH  = 3'b010;
  localparam logic [2:0] OP_LW  = 3'b011;
  localparam logic [2:0] OP_LD  = 3'b100;
  localparam logic [2:0] OP_LBU = 3'b101;
  localparam logic [2:0] OP_LHU = 3'b110;
  localparam logic [2:0] OP_LWU = 3'b111;

  localparam logic [2:0] OP_SB = 3'b001;
  localparam logic [2:0] OP_SH = 3'b010;
  localparam logic [2:0] OP_SW = 3'b011;
  localparam logic [2:0] OP_SD = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  // Store codes 101-111 are not stores; fold them to OP_NONE.
  function automatic logic [2:0] wr_norm(input logic [2:0] wr_op);
    return (wr_op inside {OP_SB, OP_SH, OP_SW, OP_SD}) ? wr_op : OP_NONE;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signal bundle of the data-memory arbiter; the
// slave modport is the arbiter's view, master is the requesters plus memory.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic [1:0]        req;
  logic [2:0]        rd_op0;
  logic [2:0]        rd_op1;
  logic [2:0]        wr_op0;
  logic [2:0]        wr_op1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [1:0]        done;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic [2:0]        mem_read;
  logic [2:0]        mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req, rd_op0, rd_op1, wr_op0, wr_op1, addr0, addr1, wdata0, wdata1,
    input  mem_rdata,
    output done, rdata, busy, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req, rd_op0, rd_op1, wr_op0, wr_op1, addr0, addr1, wdata0, wdata1,
    output mem_rdata,
    input  done, rdata, busy, mem_read, mem_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dmem_rr_pick.sv
// Combinational two-way round-robin select: a lone request wins outright,
// a tie goes to the port named by the pointer.
module dmem_rr_pick (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic       grant_valid_o,
  output logic       grant_idx_o
);

  assign grant_valid_o = |req_i;
  assign grant_idx_o   = (&req_i) ? ptr_i : req_i[1];

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory command port between two requesters; each
// transaction runs IDLE -> ACCESS -> DONE with round-robin fairness.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);

  state_e            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              owner_q, owner_d;
  logic [2:0]        cmd_rd_q, cmd_rd_d;
  logic [2:0]        cmd_wr_q, cmd_wr_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              grant_valid;
  logic              grant_idx;
  logic [2:0]        sel_rd;
  logic [2:0]        sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  dmem_rr_pick u_pick (
    .req_i         (bus.req),
    .ptr_i         (ptr_q),
    .grant_valid_o (grant_valid),
    .grant_idx_o   (grant_idx)
  );

  assign sel_rd    = grant_idx ? bus.rd_op1 : bus.rd_op0;
  assign sel_wr    = wr_norm(grant_idx ? bus.wr_op1 : bus.wr_op0);
  assign sel_addr  = grant_idx ? bus.addr1  : bus.addr0;
  assign sel_wdata = grant_idx ? bus.wdata1 : bus.wdata0;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    cmd_rd_d    = cmd_rd_q;
    cmd_wr_d    = cmd_wr_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    rdata_d     = rdata_q;

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          owner_d     = grant_idx;
          cmd_wr_d    = sel_wr;
          // A real store suppresses the load so the response reads as zero.
          cmd_rd_d    = (sel_wr != OP_NONE) ? OP_NONE : sel_rd;
          cmd_addr_d  = sel_addr;
          cmd_wdata_d = sel_wdata;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        rdata_d = (cmd_rd_q == OP_NONE) ? '0 : bus.mem_rdata;
        state_d = DONE;
      end
      DONE: begin
        ptr_d   = ~owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      owner_q     <= 1'b0;
      cmd_rd_q    <= OP_NONE;
      cmd_wr_q    <= OP_NONE;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cmd_rd_q    <= cmd_rd_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  // Gating with rst_n keeps a store or done pulse from escaping on the
  // same edge that drops an in-flight transaction.
  assign bus.mem_read  = (state_q == ACCESS && rst_n) ? cmd_rd_q : OP_NONE;
  assign bus.mem_write = (state_q == ACCESS && rst_n) ? cmd_wr_q : OP_NONE;
  assign bus.mem_addr  = cmd_addr_q;
  assign bus.mem_wdata = cmd_wdata_q;
  assign bus.done      = (state_q == DONE && rst_n) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-array memory model behind the
// memory command port.
module tb_dmem_arbiter;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;
  logic [7:0] mem [0:255];
  logic saw_rd;
  logic saw_wr;
  logic [63:0] raw;
  logic [63:0] ld_val;

  dmem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  dmem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational little-endian load with sign/zero extension.
  always_comb begin
    raw = '0;
    for (int i = 0; i < 8; i++) raw[8*i +: 8] = mem[8'(bus.mem_addr[7:0] + 8'(i))];
    case (bus.mem_read)
      3'b001:  ld_val = {{56{raw[7]}},  raw[7:0]};
      3'b010:  ld_val = {{48{raw[15]}}, raw[15:0]};
      3'b011:  ld_val = {{32{raw[31]}}, raw[31:0]};
      3'b100:  ld_val = raw;
      3'b101:  ld_val = {56'b0, raw[7:0]};
      3'b110:  ld_val = {48'b0, raw[15:0]};
      3'b111:  ld_val = {32'b0, raw[31:0]};
      default: ld_val = '0;
    endcase
    bus.mem_rdata = ld_val;
  end

  always @(posedge clk) begin
    if (bus.mem_write inside {3'b001, 3'b010, 3'b011, 3'b100}) begin
      for (int i = 0; i < (1 << (bus.mem_write - 3'd1)); i++)
        mem[8'(bus.mem_addr[7:0] + 8'(i))] <= bus.mem_wdata[8*i +: 8];
    end
  end

  always @(negedge clk) begin
    if (bus.mem_read != 3'b000)  saw_rd <= 1'b1;
    if (bus.mem_write != 3'b000) saw_wr <= 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive(input int port, input logic [2:0] rd, input logic [2:0] wr,
                       input logic [63:0] addr, input logic [63:0] wdata);
    if (port == 0) begin
      bus.rd_op0 = rd; bus.wr_op0 = wr; bus.addr0 = addr; bus.wdata0 = wdata;
    end else begin
      bus.rd_op1 = rd; bus.wr_op1 = wr; bus.addr1 = addr; bus.wdata1 = wdata;
    end
    bus.req[port] = 1'b1;
  endtask

  // Returns the first nonzero done and the cycle count; n=13 on timeout.
  task automatic wait_done(output logic [1:0] d, output int n);
    d = 2'b00;
    n = 13;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done != 2'b00) begin
        d = bus.done;
        n = k;
        break;
      end
    end
  endtask

  task automatic run_one(input int port, input logic [2:0] rd, input logic [2:0] wr,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [63:0] exp, input string tag);
    logic [1:0] d;
    int n;
    drive(port, rd, wr, addr, wdata);
    wait_done(d, n);
    chk({tag, ".lat"}, 64'(n), 64'd2);
    chk({tag, ".done"}, 64'(d), (port == 0) ? 64'd1 : 64'd2);
    chk({tag, ".rdata"}, bus.rdata, exp);
    @(posedge clk);
    #1;
    bus.req[port] = 1'b0;
  endtask

  initial begin
    logic [1:0] d;
    int n;
    logic [1:0] dones;
    n_chk  = 0;
    n_pass = 0;
    for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    for (int i = 0; i < 8; i++) mem[16 + i] <= 8'hC0 + 8'(i);
    saw_rd <= 1'b0;
    saw_wr <= 1'b0;
    rst_n = 1'b0;
    bus.req = 2'b00;
    bus.rd_op0 = 3'b0; bus.wr_op0 = 3'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.rd_op1 = 3'b0; bus.wr_op1 = 3'b0; bus.addr1 = '0; bus.wdata1 = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.done", 64'(bus.done), 64'd0);
    chk("rst.rdata", bus.rdata, 64'd0);
    chk("rst.busy", 64'(bus.busy), 64'd0);
    chk("rst.mem_read", 64'(bus.mem_read), 64'd0);
    chk("rst.mem_write", 64'(bus.mem_write), 64'd0);
    chk("rst.mem_addr", bus.mem_addr, 64'd0);
    chk("rst.mem_wdata", bus.mem_wdata, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Store dropped by a reset sampled in its ACCESS cycle.
    drive(0, 3'b000, 3'b100, 64'h10, 64'hDEAD_BEEF_0BAD_F00D);
    @(posedge clk);
    #1;
    chk("midrst.busy", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    bus.req = 2'b00;
    @(negedge clk);
    chk("midrst.mem_write", 64'(bus.mem_write), 64'd0);
    dones = 2'b00;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      dones = dones | bus.done;
    end
    chk("midrst.no_done", 64'(dones), 64'd0);
    chk("midrst.busy_after", 64'(bus.busy), 64'd0);
    chk("midrst.mem_addr", bus.mem_addr, 64'd0);
    chk("midrst.rdata", bus.rdata, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_one(0, 3'b100, 3'b000, 64'h10, 64'h0, 64'hC7C6_C5C4_C3C2_C1C0, "ld_prerst");

    run_one(0, 3'b000, 3'b100, 64'h10, 64'h1122_3344_5566_7788, 64'h0, "sd");
    run_one(0, 3'b100, 3'b000, 64'h10, 64'h0, 64'h1122_3344_5566_7788, "ld");
    // Store code 101 is not a store, so the load goes ahead.
    run_one(0, 3'b100, 3'b101, 64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1122_3344_5566_7788, "badwr");

    // Both ports held after a fresh reset: service order 0,1,0,1.
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(0, 3'b011, 3'b000, 64'h10, 64'h0);
    drive(1, 3'b101, 3'b000, 64'h17, 64'h0);
    for (int k = 0; k < 4; k++) begin
      wait_done(d, n);
      chk($sformatf("dual%0d.lat", k), 64'(n), (k == 0) ? 64'd2 : 64'd3);
      chk($sformatf("dual%0d.done", k), 64'(d), (k % 2 == 0) ? 64'd1 : 64'd2);
      chk($sformatf("dual%0d.rdata", k), bus.rdata,
          (k % 2 == 0) ? 64'h0000_0000_5566_7788 : 64'h11);
    end
    @(posedge clk);
    #1 bus.req = 2'b00;

    saw_rd <= 1'b0;
    #1;
    run_one(1, 3'b011, 3'b001, 64'h20, 64'hAB, 64'h0, "wprec");
    chk("wprec.mem_read", 64'(saw_rd), 64'd0);
    chk("wprec.byte", 64'(mem[32]), 64'hAB);
    run_one(0, 3'b101, 3'b000, 64'h20, 64'h0, 64'hAB, "lbu20");
    run_one(1, 3'b001, 3'b000, 64'h20, 64'h0, 64'hFFFF_FFFF_FFFF_FFAB, "lb20");

    saw_wr <= 1'b0;
    #1;
    run_one(0, 3'b000, 3'b000, 64'h30, 64'h55, 64'h0, "noop");
    chk("noop.mem_write", 64'(saw_wr), 64'd0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
